tmr_err_collector: RTL and testbench

Aggregation stage downstream of the TMR voter error sinks. Collects the per-instance error flags raised by triplicated submodules and turns them into sticky per-source status bits, a saturating error-event counter, a first-offender index and an alarm. Clearing uses a request/acknowledge handshake driven by the system controller. Its own `err_o` carries the `tmrx_error_sink` attribute so that the TMR pass treats it as the design-level error sink.

---
 rtl/tmr_err_collector.sv | 121 ++++++++++++
 tb/tb_tmr_err_collector.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_err_collector.sv
// Error aggregation behind the TMR voter sinks. Produces sticky per-source status,
// a saturating event counter, the first offender and an alarm, with a req/ack clear.
module tmr_err_collector #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned THRESH  = 3,
    localparam int unsigned FirstW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_SRC-1:0]  err_i,
    input  logic                clr_req_i,
    output logic                clr_ack_o,
    output logic [NUM_SRC-1:0]  status_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [FirstW-1:0]   first_src_o,
    (* tmrx_error_sink *)
    output logic                err_o,
    output logic                alarm_o
);

    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ThreshVal = CNT_W'(THRESH);

    typedef enum logic [1:0] {StIdle, StLatched, StClear} state_e;

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   status_q, status_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FirstW-1:0]    first_q, first_d;
    logic                 ack_q, ack_d;
    logic [FirstW-1:0]    low_idx;
    logic                 any_err;

    assign any_err = |err_i;

    // Scan downwards so the lowest set index wins.
    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (err_i[i]) begin
                low_idx = FirstW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        ack_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_err) begin
                    status_d = err_i;
                    cnt_d    = CNT_W'(1);
                    first_d  = low_idx;
                    state_d  = StLatched;
                end else if (clr_req_i) begin
                    state_d = StClear;
                    ack_d   = 1'b1;
                end
            end
            StLatched: begin
                status_d = status_q | err_i;
                if (any_err && (cnt_q != CntMax)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (clr_req_i) begin
                    state_d = StClear;
                    ack_d   = 1'b1;
                end
            end
            StClear: begin
                // Clear first, then treat this cycle's errors as a fresh IDLE capture.
                if (any_err) begin
                    status_d = err_i;
                    cnt_d    = CNT_W'(1);
                    first_d  = low_idx;
                    state_d  = StLatched;
                end else begin
                    status_d = '0;
                    cnt_d    = '0;
                    first_d  = '0;
                    state_d  = StIdle;
                end
            end
            default: begin
                status_d = '0;
                cnt_d    = '0;
                first_d  = '0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            status_q <= '0;
            cnt_q    <= '0;
            first_q  <= '0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            ack_q    <= ack_d;
        end
    end

    assign clr_ack_o   = ack_q;
    assign status_o    = status_q;
    assign cnt_o       = cnt_q;
    assign first_src_o = first_q;
    assign err_o       = |status_q;
    assign alarm_o     = (cnt_q >= ThreshVal);

endmodule

// File: tb/tb_tmr_err_collector.sv
// Scoreboard bench for tmr_err_collector: a behavioural model queues expected outputs
// per driven cycle; a CNT_W=2 instance covers counter saturation.
module tb_tmr_err_collector;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] err_i = '0;
    logic       clr_req_i = 1'b0;
    logic       clr_ack_o;
    logic [3:0] status_o;
    logic [7:0] cnt_o;
    logic [1:0] first_src_o;
    logic       err_o;
    logic       alarm_o;

    logic [3:0] err_s = '0;
    logic       clr_s = 1'b0;
    logic       ack_s;
    logic [3:0] status_s;
    logic [1:0] cnt_s;
    logic [1:0] first_s;
    logic       err_os;
    logic       alarm_s;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] status;
        logic [7:0] cnt;
        logic [1:0] first;
        logic       err;
        logic       alarm;
        logic       ack;
    } exp_t;

    exp_t sb[$];

    // Reference model state: 0 idle, 1 latched, 2 clear
    int         m_state = 0;
    logic [3:0] m_status = '0;
    logic [7:0] m_cnt = '0;
    logic [1:0] m_first = '0;
    logic       m_ack = 1'b0;

    tmr_err_collector #(.NUM_SRC(4), .CNT_W(8), .THRESH(3)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .err_i      (err_i),
        .clr_req_i  (clr_req_i),
        .clr_ack_o  (clr_ack_o),
        .status_o   (status_o),
        .cnt_o      (cnt_o),
        .first_src_o(first_src_o),
        .err_o      (err_o),
        .alarm_o    (alarm_o)
    );

    tmr_err_collector #(.NUM_SRC(4), .CNT_W(2), .THRESH(3)) dut_sat (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .err_i      (err_s),
        .clr_req_i  (clr_s),
        .clr_ack_o  (ack_s),
        .status_o   (status_s),
        .cnt_o      (cnt_s),
        .first_src_o(first_s),
        .err_o      (err_os),
        .alarm_o    (alarm_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] lowest(input logic [3:0] e);
        for (int i = 0; i < 4; i++) begin
            if (e[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_status = '0; m_cnt = '0; m_first = '0; m_ack = 1'b0;
        sb.delete();
    endtask

    task automatic model_edge(input logic [3:0] e, input logic r);
        case (m_state)
            0: begin
                m_ack = 1'b0;
                if (e != 0) begin
                    m_status = e; m_cnt = 8'd1; m_first = lowest(e); m_state = 1;
                end else if (r) begin
                    m_state = 2; m_ack = 1'b1;
                end
            end
            1: begin
                m_status = m_status | e;
                if (e != 0 && m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
                m_ack = r;
                if (r) m_state = 2;
            end
            default: begin
                m_ack = 1'b0;
                if (e != 0) begin
                    m_status = e; m_cnt = 8'd1; m_first = lowest(e); m_state = 1;
                end else begin
                    m_status = '0; m_cnt = '0; m_first = '0; m_state = 0;
                end
            end
        endcase
    endtask

    // Drive one cycle of stimulus, queue the model's expectation, compare after the edge.
    task automatic step(input logic [3:0] e, input logic r);
        exp_t x;
        err_i = e;
        clr_req_i = r;
        model_edge(e, r);
        x.status = m_status;
        x.cnt    = m_cnt;
        x.first  = m_first;
        x.err    = |m_status;
        x.alarm  = (m_cnt >= 8'd3);
        x.ack    = m_ack;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            check("status", 32'(status_o), 32'(x.status));
            check("cnt", 32'(cnt_o), 32'(x.cnt));
            check("first", 32'(first_src_o), 32'(x.first));
            check("err", 32'(err_o), 32'(x.err));
            check("alarm", 32'(alarm_o), 32'(x.alarm));
            check("ack", 32'(clr_ack_o), 32'(x.ack));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_status"}, 32'(status_o), 32'd0);
        check({tag, "_cnt"}, 32'(cnt_o), 32'd0);
        check({tag, "_first"}, 32'(first_src_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_alarm"}, 32'(alarm_o), 32'd0);
        check({tag, "_ack"}, 32'(clr_ack_o), 32'd0);
    endtask

    task automatic do_clear();
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_ni = 1'b1;

        // Single source
        step(4'b0100, 1'b0);
        check("single_status", 32'(status_o), 32'h4);
        check("single_first", 32'(first_src_o), 32'd2);
        step(4'b0000, 1'b0);
        do_clear();

        // Accumulation and alarm
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b1001, 1'b0);
        check("acc_alarm_early", 32'(alarm_o), 32'd0);
        step(4'b0001, 1'b0);
        check("acc_status", 32'(status_o), 32'hb);
        check("acc_cnt", 32'(cnt_o), 32'd3);
        check("acc_alarm", 32'(alarm_o), 32'd1);
        check("acc_first", 32'(first_src_o), 32'd1);
        do_clear();

        // Clear handshake from status 0011
        step(4'b0011, 1'b0);
        step(4'b0000, 1'b1);
        check("hs_ack", 32'(clr_ack_o), 32'd1);
        step(4'b0000, 1'b0);
        check("hs_status", 32'(status_o), 32'd0);
        check("hs_ack_low", 32'(clr_ack_o), 32'd0);
        step(4'b0000, 1'b0);

        // Collision: error at request edge is kept, error during CLEAR survives
        step(4'b0001, 1'b0);
        step(4'b0100, 1'b1);
        check("col_pre_status", 32'(status_o), 32'h5);
        step(4'b1000, 1'b0);
        check("col_status", 32'(status_o), 32'h8);
        check("col_cnt", 32'(cnt_o), 32'd1);
        check("col_first", 32'(first_src_o), 32'd3);
        do_clear();

        // Error has priority over a clear request in IDLE
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);

        // Request held past the ack: second clear after a one-cycle gap
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);

        // Saturation of the 8-bit counter
        for (int i = 0; i < 260; i++) step(4'b0001, 1'b0);
        check("sat8_cnt", 32'(cnt_o), 32'hff);
        do_clear();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                 ($urandom_range(0, 5) == 0));
        end
        do_clear();
        step(4'b0000, 1'b0);

        // Asynchronous reset mid-run with cnt = 5
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b0);
        check("pre_rst_cnt", 32'(cnt_o), 32'd5);
        err_i = 4'b0001;
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        rst_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);
        check_all_zero("post_rst_idle");

        // CNT_W=2 instance: counter sticks at 3
        for (int i = 0; i < 6; i++) begin
            err_s = 4'b0001;
            @(posedge clk);
            #1;
            check("sat2_cnt", 32'(cnt_s), (i < 2) ? 32'(i + 1) : 32'd3);
        end
        check("sat2_alarm", 32'(alarm_s), 32'd1);
        err_s = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
